// File: rtl/formation_ctl.sv
// formation_ctl: frame-rate sequencer for the invader formation anchor.
// Counts vsync frames, marches the anchor right/left between X_MIN and X_MAX,
// drops it by STEP_Y at each edge and toggles the animation frame per step.
// Optional feature macro: FORMATION_SPEEDUP_EN (period follows alive_count,
// clamped below at MIN_PERIOD). Without it the period is BASE_PERIOD.
module formation_ctl #(
  parameter int X_MIN       = 16,
  parameter int X_MAX       = 48,
  parameter int Y_START     = 32,
  parameter int Y_LAND      = 80,
  parameter int STEP_X      = 8,
  parameter int STEP_Y      = 16,
  parameter int BASE_PERIOD = 4,
  parameter int MIN_PERIOD  = 2,
  parameter int ANIM_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vsync,
  input  logic        start,
  input  logic        pause,
  input  logic [5:0]  alive_count,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic [1:0]  anim_frame,
  output logic        moving,
  output logic        step_pulse,
  output logic        landed
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MOVE_R = 3'd1,
    S_MOVE_L = 3'd2,
    S_DROP   = 3'd3,
    S_LANDED = 3'd4
  } state_t;

  // 13-bit copies of the geometry so sums and compares never wrap
  localparam logic [12:0] X_MIN_W   = 13'(X_MIN);
  localparam logic [12:0] X_MAX_W   = 13'(X_MAX);
  localparam logic [12:0] Y_LAND_W  = 13'(Y_LAND);
  localparam logic [12:0] STEP_X_W  = 13'(STEP_X);
  localparam logic [12:0] STEP_Y_W  = 13'(STEP_Y);
  localparam logic [11:0] X_MIN_12  = 12'(X_MIN);
  localparam logic [11:0] Y_START_12 = 12'(Y_START);
  localparam logic [11:0] STEP_X_12 = 12'(STEP_X);
  localparam logic [5:0]  BASE_P    = 6'(BASE_PERIOD);
  localparam logic [5:0]  MIN_P     = 6'(MIN_PERIOD);
  localparam logic [1:0]  ANIM_LAST = 2'(ANIM_FRAMES - 1);

  state_t      state_q, state_d;
  logic        dir_q, dir_d;
  logic [5:0]  frame_cnt_q, frame_cnt_d;
  logic [5:0]  period_q, period_d;
  logic [11:0] xpos_q, xpos_d;
  logic [11:0] ypos_q, ypos_d;
  logic [1:0]  anim_q, anim_d;
  logic        moving_q, moving_d;
  logic        step_pulse_q, step_pulse_d;
  logic        landed_q, landed_d;
  logic        q1_q, q1_d;
  logic        q2_q, q2_d;

  logic [5:0]  period_new_s;
  logic        tick_s;
  logic        running_s;
  logic        step_s;
  logic [12:0] x_add_s;
  logic [11:0] x_sub_s;
  logic [12:0] y_add_s;

`ifdef FORMATION_SPEEDUP_EN
  // Step period tracks the number of live invaders, never below MIN_PERIOD
  always_comb begin
    if (alive_count < MIN_P) begin
      period_new_s = MIN_P;
    end else begin
      period_new_s = alive_count;
    end
  end
`else
  logic unused_alive_s;
  assign unused_alive_s = ^alive_count;
  assign period_new_s   = BASE_P;
`endif

  assign tick_s    = q1_q & ~q2_q & ~pause;
  assign running_s = (state_q == S_MOVE_R) || (state_q == S_MOVE_L) || (state_q == S_DROP);
  assign step_s    = running_s && tick_s && (frame_cnt_q >= (period_q - 6'd1));
  assign x_add_s   = {1'b0, xpos_q} + STEP_X_W;
  assign x_sub_s   = xpos_q - STEP_X_12;
  assign y_add_s   = {1'b0, ypos_q} + STEP_Y_W;

  // Next-state logic: start has priority, then frame ticks while marching
  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    frame_cnt_d  = frame_cnt_q;
    period_d     = period_q;
    xpos_d       = xpos_q;
    ypos_d       = ypos_q;
    anim_d       = anim_q;
    landed_d     = landed_q;
    step_pulse_d = 1'b0;
    q1_d         = vsync;
    q2_d         = q1_q;

    if (start) begin
      state_d     = S_MOVE_R;
      dir_d       = 1'b0;
      frame_cnt_d = 6'd0;
      period_d    = period_new_s;
      xpos_d      = X_MIN_12;
      ypos_d      = Y_START_12;
      anim_d      = 2'd0;
      landed_d    = 1'b0;
    end else if (running_s && tick_s) begin
      if (step_s) begin
        frame_cnt_d  = 6'd0;
        period_d     = period_new_s;
        step_pulse_d = 1'b1;
        if (anim_q >= ANIM_LAST) begin
          anim_d = 2'd0;
        end else begin
          anim_d = anim_q + 2'd1;
        end
        case (state_q)
          S_MOVE_R: begin
            if (x_add_s <= X_MAX_W) begin
              xpos_d = x_add_s[11:0];
            end else begin
              state_d = S_DROP;
              dir_d   = 1'b1;
            end
          end
          S_MOVE_L: begin
            if ({1'b0, xpos_q} >= (X_MIN_W + STEP_X_W)) begin
              xpos_d = x_sub_s;
            end else begin
              state_d = S_DROP;
              dir_d   = 1'b0;
            end
          end
          S_DROP: begin
            ypos_d = y_add_s[11:0];
            if (y_add_s >= Y_LAND_W) begin
              state_d  = S_LANDED;
              landed_d = 1'b1;
            end else if (dir_q) begin
              state_d = S_MOVE_L;
            end else begin
              state_d = S_MOVE_R;
            end
          end
          default: begin
            state_d = state_q;
          end
        endcase
      end else begin
        frame_cnt_d = frame_cnt_q + 6'd1;
      end
    end else begin
      frame_cnt_d = frame_cnt_q;
    end

    moving_d = (state_d == S_MOVE_R) || (state_d == S_MOVE_L) || (state_d == S_DROP);
  end

  // State and output registers, cleared asynchronously by rst_n
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      dir_q        <= 1'b0;
      frame_cnt_q  <= 6'd0;
      period_q     <= BASE_P;
      xpos_q       <= X_MIN_12;
      ypos_q       <= Y_START_12;
      anim_q       <= 2'd0;
      moving_q     <= 1'b0;
      step_pulse_q <= 1'b0;
      landed_q     <= 1'b0;
      q1_q         <= 1'b0;
      q2_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      frame_cnt_q  <= frame_cnt_d;
      period_q     <= period_d;
      xpos_q       <= xpos_d;
      ypos_q       <= ypos_d;
      anim_q       <= anim_d;
      moving_q     <= moving_d;
      step_pulse_q <= step_pulse_d;
      landed_q     <= landed_d;
      q1_q         <= q1_d;
      q2_q         <= q2_d;
    end
  end

  assign xpos       = xpos_q;
  assign ypos       = ypos_q;
  assign anim_frame = anim_q;
  assign moving     = moving_q;
  assign step_pulse = step_pulse_q;
  assign landed     = landed_q;

endmodule

// File: tb/tb_formation_ctl.sv
// Directed testbench for formation_ctl with default parameters.
module tb_formation_ctl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vsync = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic [5:0]  alive_count = 6'd0;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic [1:0]  anim_frame;
  logic        moving;
  logic        step_pulse;
  logic        landed;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;

  formation_ctl dut (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .start(start), .pause(pause),
    .alive_count(alive_count), .xpos(xpos), .ypos(ypos), .anim_frame(anim_frame),
    .moving(moving), .step_pulse(step_pulse), .landed(landed)
  );

  always #5 clk = ~clk;

  // One vsync frame: 3 cycles high, 3 low; counts step pulses seen at negedges
  task automatic frame();
    @(negedge clk) vsync = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (step_pulse) pulse_cnt++;
      if (i == 2) vsync = 1'b0;
    end
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) frame();
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (xpos !== 12'd16) begin errors++; $display("FAIL rst_x got %0d exp 16", xpos); end
    checks++; if (ypos !== 12'd32) begin errors++; $display("FAIL rst_y got %0d exp 32", ypos); end
    checks++; if (anim_frame !== 2'd0) begin errors++; $display("FAIL rst_anim got %0d exp 0", anim_frame); end
    checks++; if ({moving, step_pulse, landed} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b exp 000", {moving, step_pulse, landed}); end
    rst_n = 1'b1;
    pulse_cnt = 0;
    frames(6);
    checks++; if (xpos !== 12'd16 || moving !== 1'b0 || pulse_cnt != 0) begin errors++; $display("FAIL idle_ignores_ticks got x=%0d mv=%b p=%0d exp 16 0 0", xpos, moving, pulse_cnt); end
  endtask

  task automatic test_march_right();
    pulse_start();
    checks++; if (moving !== 1'b1 || xpos !== 12'd16) begin errors++; $display("FAIL start_apply got mv=%b x=%0d exp 1 16", moving, xpos); end
    pulse_cnt = 0;
    frames(3);
    checks++; if (xpos !== 12'd16 || pulse_cnt != 0) begin errors++; $display("FAIL mr_3frames got x=%0d p=%0d exp 16 0", xpos, pulse_cnt); end
    @(negedge clk) vsync = 1'b1;
    @(negedge clk);
    checks++; if (xpos !== 12'd16 || step_pulse !== 1'b0) begin errors++; $display("FAIL mr_tick_cycle got x=%0d sp=%b exp 16 0", xpos, step_pulse); end
    @(negedge clk);
    checks++; if (xpos !== 12'd24) begin errors++; $display("FAIL mr_step_x got %0d exp 24", xpos); end
    checks++; if (anim_frame !== 2'd1) begin errors++; $display("FAIL mr_step_anim got %0d exp 1", anim_frame); end
    checks++; if (step_pulse !== 1'b1) begin errors++; $display("FAIL mr_pulse_hi got %b exp 1", step_pulse); end
    @(negedge clk) vsync = 1'b0;
    checks++; if (step_pulse !== 1'b0) begin errors++; $display("FAIL mr_pulse_one_cycle got %b exp 0", step_pulse); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_right_drop();
    frames(12);
    checks++; if (xpos !== 12'd48 || ypos !== 12'd32) begin errors++; $display("FAIL rd_at_edge got %0d/%0d exp 48/32", xpos, ypos); end
    frames(4);
    checks++; if (xpos !== 12'd48 || ypos !== 12'd32 || moving !== 1'b1) begin errors++; $display("FAIL rd_enter_drop got %0d/%0d mv=%b exp 48/32 1", xpos, ypos, moving); end
    frames(4);
    checks++; if (xpos !== 12'd48 || ypos !== 12'd48 || moving !== 1'b1) begin errors++; $display("FAIL rd_dropped got %0d/%0d mv=%b exp 48/48 1", xpos, ypos, moving); end
    frames(4);
    checks++; if (xpos !== 12'd40 || ypos !== 12'd48 || moving !== 1'b1) begin errors++; $display("FAIL rd_move_left got %0d/%0d mv=%b exp 40/48 1", xpos, ypos, moving); end
    checks++; if (anim_frame !== 2'd1) begin errors++; $display("FAIL rd_anim got %0d exp 1", anim_frame); end
  endtask

  task automatic test_landing();
    frames(20);
    checks++; if (xpos !== 12'd16 || ypos !== 12'd64) begin errors++; $display("FAIL ld_left_drop got %0d/%0d exp 16/64", xpos, ypos); end
    frames(24);
    checks++; if (xpos !== 12'd48 || ypos !== 12'd80) begin errors++; $display("FAIL ld_pos got %0d/%0d exp 48/80", xpos, ypos); end
    checks++; if (landed !== 1'b1 || moving !== 1'b0) begin errors++; $display("FAIL ld_flags got l=%b mv=%b exp 1 0", landed, moving); end
    checks++; if (anim_frame !== 2'd0) begin errors++; $display("FAIL ld_anim got %0d exp 0", anim_frame); end
    pulse_cnt = 0;
    frames(8);
    checks++; if (xpos !== 12'd48 || ypos !== 12'd80 || anim_frame !== 2'd0 || landed !== 1'b1 || pulse_cnt != 0) begin errors++; $display("FAIL ld_frozen got %0d/%0d a=%0d l=%b p=%0d exp 48/80 0 1 0", xpos, ypos, anim_frame, landed, pulse_cnt); end
    pulse_start();
    checks++; if (xpos !== 12'd16 || ypos !== 12'd32 || anim_frame !== 2'd0) begin errors++; $display("FAIL ld_restart_pos got %0d/%0d a=%0d exp 16/32 0", xpos, ypos, anim_frame); end
    checks++; if (landed !== 1'b0 || moving !== 1'b1) begin errors++; $display("FAIL ld_restart_flags got l=%b mv=%b exp 0 1", landed, moving); end
  endtask

  task automatic test_pause_vs_start();
    frames(4);
    checks++; if (xpos !== 12'd24) begin errors++; $display("FAIL ps_pre got %0d exp 24", xpos); end
    frames(2);
    pause = 1'b1;
    pulse_cnt = 0;
    frames(10);
    checks++; if (xpos !== 12'd24 || anim_frame !== 2'd1 || pulse_cnt != 0) begin errors++; $display("FAIL ps_frozen got x=%0d a=%0d p=%0d exp 24 1 0", xpos, anim_frame, pulse_cnt); end
    pulse_start();
    checks++; if (xpos !== 12'd16 || anim_frame !== 2'd0) begin errors++; $display("FAIL ps_start got x=%0d a=%0d exp 16 0", xpos, anim_frame); end
    frames(4);
    checks++; if (xpos !== 12'd16 || pulse_cnt != 0) begin errors++; $display("FAIL ps_still_paused got x=%0d p=%0d exp 16 0", xpos, pulse_cnt); end
    pause = 1'b0;
    frames(3);
    checks++; if (xpos !== 12'd16) begin errors++; $display("FAIL ps_resume_3 got %0d exp 16", xpos); end
    frames(1);
    checks++; if (xpos !== 12'd24 || pulse_cnt != 1) begin errors++; $display("FAIL ps_resume_4 got x=%0d p=%0d exp 24 1", xpos, pulse_cnt); end
  endtask

`ifdef FORMATION_SPEEDUP_EN
  task automatic test_speedup();
    alive_count = 6'd1;
    pulse_start();
    frames(1);
    checks++; if (xpos !== 12'd16) begin errors++; $display("FAIL su_1frame got %0d exp 16", xpos); end
    frames(1);
    checks++; if (xpos !== 12'd24) begin errors++; $display("FAIL su_2frames got %0d exp 24", xpos); end
    alive_count = 6'd10;
    frames(2);
    checks++; if (xpos !== 12'd32) begin errors++; $display("FAIL su_latched_old got %0d exp 32", xpos); end
    frames(9);
    checks++; if (xpos !== 12'd32) begin errors++; $display("FAIL su_10_wait got %0d exp 32", xpos); end
    frames(1);
    checks++; if (xpos !== 12'd40) begin errors++; $display("FAIL su_10_step got %0d exp 40", xpos); end
  endtask
`endif

  task automatic test_async_reset();
    pulse_start();
    frames(36);
    checks++; if (xpos !== 12'd24 || ypos !== 12'd48 || moving !== 1'b1) begin errors++; $display("FAIL ar_pre got %0d/%0d mv=%b exp 24/48 1", xpos, ypos, moving); end
    frames(2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (xpos !== 12'd16 || ypos !== 12'd32) begin errors++; $display("FAIL ar_pos got %0d/%0d exp 16/32", xpos, ypos); end
    checks++; if ({moving, landed, step_pulse} !== 3'b000 || anim_frame !== 2'd0) begin errors++; $display("FAIL ar_flags got %b a=%0d exp 000 0", {moving, landed, step_pulse}, anim_frame); end
    @(negedge clk) rst_n = 1'b1;
    pulse_cnt = 0;
    frames(8);
    checks++; if (xpos !== 12'd16 || moving !== 1'b0 || pulse_cnt != 0) begin errors++; $display("FAIL ar_idle got x=%0d mv=%b p=%0d exp 16 0 0", xpos, moving, pulse_cnt); end
    pulse_start();
    frames(4);
    checks++; if (xpos !== 12'd24 || moving !== 1'b1) begin errors++; $display("FAIL ar_restart got x=%0d mv=%b exp 24 1", xpos, moving); end
  endtask

  initial begin
    test_reset();
    test_march_right();
    test_right_drop();
    test_landing();
    test_pause_vs_start();
`ifdef FORMATION_SPEEDUP_EN
    test_speedup();
`endif
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/formation_ctl.md
# formation_ctl

Frame-rate sequencer for the invader formation sprite. Counts frames from the VGA vsync, marches the formation's top-left anchor right and left between fixed bounds, drops it one row at each edge, and toggles the animation frame on every step. Its `xpos`/`ypos` outputs drive the position inputs of the sprite-drawing stage. Its `anim_frame` output selects the sprite-sheet column. Updates land in vertical blanking, so a frame is never drawn with a torn position.

## Interface
- `X_MIN`, 16: leftmost allowed anchor x (pixels).
- `X_MAX`, 48: rightmost allowed anchor x (pixels).
- `Y_START`, 32: anchor y after reset or start.
- `Y_LAND`, 80: anchor y at or beyond which the formation has landed.
- `STEP_X`, 8: horizontal step size (pixels).
- `STEP_Y`, 16: drop size (pixels).
- `BASE_PERIOD`, 4: frames per step when speed-up is compiled out. Range 1..63.
- `MIN_PERIOD`, 2: lower clamp on frames per step when speed-up is compiled in. Range 1..63.
- `ANIM_FRAMES`, 2: number of animation frames. Range 1..4.
- `clk`  in  1  pixel clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `vsync`  in  1  VGA vsync, taken from the timing-interface output.
- `start`  in  1  one-cycle pulse that (re)starts the march.
- `pause`  in  1  level input; while high, frame ticks are ignored.
- `alive_count`  in  6  invaders still alive. Used only when `FORMATION_SPEEDUP_EN` is defined.
- `xpos`  out  12  formation anchor x.
- `ypos`  out  12  formation anchor y.
- `anim_frame`  out  2  animation frame index, 0..ANIM_FRAMES-1.
- `moving`  out  1  high in the MOVE_R, MOVE_L and DROP states.
- `step_pulse`  out  1  one-cycle pulse on every step, including drops.
- `landed`  out  1  sticky; cleared only by `start` or reset.

## Operation
- **Frame tick:** `vsync` is registered twice (`q1`, `q2`). `tick = q1 & ~q2 & ~pause`.
- **States:** IDLE, MOVE_R, MOVE_L, DROP, LANDED. A direction register `dir` (0 = right) records the heading for DROP.
- **IDLE:** outputs hold their values and ticks are ignored. `start` moves to MOVE_R.
- **`start` in any state:**
  - Sets `xpos=X_MIN`, `ypos=Y_START`, `anim_frame=0`, `dir=0`.
  - Clears `frame_cnt` and `landed`.
  - Enters MOVE_R.
  - `start` overrides a coincident tick.
- **Frame counter:** in the MOVE_R, MOVE_L and DROP states, each tick increments `frame_cnt`. When `frame_cnt == period-1`, a step occurs and `frame_cnt` clears to 0.
- **Step in MOVE_R:** if `xpos+STEP_X <= X_MAX`, then `xpos += STEP_X`. Otherwise, enter DROP with `dir=1`; x is unchanged on this step.
- **Step in MOVE_L:** if `xpos >= X_MIN+STEP_X`, then `xpos -= STEP_X`. Otherwise, enter DROP with `dir=0`.
- **Step in DROP:**
  - `ypos += STEP_Y`.
  - If the new `ypos >= Y_LAND`, enter LANDED and set `landed=1`.
  - Otherwise, enter MOVE_L if `dir=1`, or MOVE_R if `dir=0`.
- **Every step:** `anim_frame` advances by 1 and wraps from ANIM_FRAMES-1 to 0. `step_pulse` is high for exactly one cycle.
- **LANDED:** positions are frozen and ticks are ignored. Only `start` or reset leaves this state.
- **Arithmetic:** all comparisons and sums are done in 13 bits, so no wrap-around can occur.
- **`pause`:** freezes `frame_cnt` and all position and animation state. It does not block `start`.

## Timing
- **Reset values:**
  - `xpos=X_MIN`, `ypos=Y_START`, `anim_frame=0`.
  - `moving=0`, `step_pulse=0`, `landed=0`.
  - State IDLE, `frame_cnt=0`, `q1=q2=0`, `dir=0`.
- **Tick latency:** a rising `vsync` first sampled at edge E0 gives `tick` high during the E0–E1 cycle. Step updates to `xpos`, `ypos`, `anim_frame` and `step_pulse` appear at E1.
- **Start latency:** `start` sampled at edge E applies its effects at E. All outputs are registered.
- **Period latch:** `period` is latched when each step occurs and when `start` is applied. A change to `alive_count` takes effect from the next step interval.
- **Reset mid-operation:** asserting `rst_n` low forces the reset values immediately and asynchronously. Deassertion is assumed synchronised upstream.

## Configuration
- `FORMATION_SPEEDUP_EN` defined: `period = max(MIN_PERIOD, alive_count)`. The formation speeds up as invaders die. `alive_count=0` yields MIN_PERIOD.
- `FORMATION_SPEEDUP_EN` undefined: `period = BASE_PERIOD`, and `alive_count` is unused.

## Test plan
Default parameters are used throughout, with `FORMATION_SPEEDUP_EN` undefined unless stated.
- **March right:** reset, then pulse `start`, then apply 4 vsync pulses.
  - Required: `xpos` 16→24 one edge after the 4th rising edge is sampled, `anim_frame=1`, and `step_pulse` high for exactly 1 cycle.
- **Right-edge drop:** run to `xpos=48`, then apply 4 more frames, then 4 more.
  - Required: first `ypos` 32→48 with `xpos=48`, then `xpos=40` with `moving` high throughout.
- **Landing:** march through the drops at right (ypos 48), left (ypos 64) and right (ypos 80).
  - Required: at `ypos=80`, `landed=1` and `moving=0`. Further vsyncs leave all outputs unchanged. A subsequent `start` restores 16/32/0 and `landed=0`.
- **Pause vs start:** hold `pause` high across 10 vsyncs, then pulse `start` while `pause` is still high.
  - Required: no output changes during the pause. `start` still resets the position, and stepping resumes only after `pause` falls.
- **Speed-up** (`FORMATION_SPEEDUP_EN` defined, `alive_count=1`):
  - Required: steps every 2 frames, clamped to MIN_PERIOD. Changing to `alive_count=10` gives 10-frame steps after the next step.
- **Asynchronous reset:** assert `rst_n=0` mid-frame during MOVE_L with `xpos=24`.
  - Required: `xpos=16`, `ypos=32` and state IDLE without a clock edge. Vsyncs are then ignored until `start`.
